// File: rtl/riscv_m_unit.sv
// riscv_m_unit: multi-cycle RV32M multiply/divide co-processor with three
// custom modular-arithmetic instructions (ADDMOD, SUBMOD, MULQ) on custom-0.
// One instruction at a time; result is returned with a one-cycle ready/wr pulse.
module riscv_m_unit #(
    parameter int unsigned Q = 3329
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [31:0] instruction,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        wr,
    output logic [31:0] rd,
    output logic        busy,
    output logic        ready
);

    localparam logic [31:0] QV = 32'(Q);

    typedef enum logic [2:0] {
        S_IDLE, S_MUL, S_DIV, S_MOD, S_MULQ, S_DONE
    } state_t;

    // ---------------------------------------------------------------
    // Modular helpers (operands assumed already reduced below Q)
    // ---------------------------------------------------------------
    function automatic logic [31:0] addmod_f(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, QV}) s = s - {1'b0, QV};
        return s[31:0];
    endfunction

    function automatic logic [31:0] submod_f(input logic [31:0] x, input logic [31:0] y);
        logic [32:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[32]) d = d + {1'b0, QV};
        return d[31:0];
    endfunction

    // Two's-complement sign restore of a magnitude
    function automatic logic [31:0] apply_sign_f(input logic [31:0] mag, input logic neg);
        return neg ? (~mag + 32'd1) : mag;
    endfunction

    // ---------------------------------------------------------------
    // Decode
    // ---------------------------------------------------------------
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_m, is_c, accept, div_sgn_in;
    logic signed [31:0] rs1_s, rs2_s;
    logic [31:0] rs1_mag, rs2_mag;

    state_t      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [31:0] rd_q, res_c;
    logic        ld_rd;

    logic [31:0] a_q, b_q;
    logic [2:0]  op_q;
    logic        dz_q, negq_q, negr_q;
    logic [63:0] sh_q, sh_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    assign is_m   = (opcode == 7'b0110011) && (funct7 == 7'b0000001);
    assign is_c   = (opcode == 7'b0001011) && (funct3 <= 3'b010);
    assign accept = valid && (state_q == S_IDLE) && (is_m || is_c);

    // DIV and REM treat operands as signed; DIVU/REMU do not
    assign div_sgn_in = is_m && funct3[2] && !funct3[0];
    assign rs1_s      = rs1;
    assign rs2_s      = rs2;
    assign rs1_mag    = (div_sgn_in && rs1_s < 0) ? 32'(-rs1_s) : rs1;
    assign rs2_mag    = (div_sgn_in && rs2_s < 0) ? 32'(-rs2_s) : rs2;

    // ---------------------------------------------------------------
    // Shared multiplier: 33x33 signed covers every MUL flavour; MULQ is unsigned
    // ---------------------------------------------------------------
    logic               a_sx, b_sx;
    logic signed [65:0] a_w, b_w, prod;

    assign a_sx = (state_q == S_MUL) && (op_q == 3'b001 || op_q == 3'b010) && a_q[31];
    assign b_sx = (state_q == S_MUL) && (op_q == 3'b001) && b_q[31];
    assign a_w  = {{34{a_sx}}, a_q};
    assign b_w  = {{34{b_sx}}, b_q};
    assign prod = a_w * b_w;

    // ---------------------------------------------------------------
    // Shared restoring step: one bit from the top of sh_q into the remainder
    // ---------------------------------------------------------------
    logic [32:0] rs_c, rem_nx;
    logic        ge_c;
    logic [63:0] sh_nx;

    assign rs_c   = {rem_q, sh_q[63]};
    assign ge_c   = rs_c >= {1'b0, dvs_q};
    assign rem_nx = ge_c ? (rs_c - {1'b0, dvs_q}) : rs_c;
    assign sh_nx  = {sh_q[62:0], ge_c};

    logic unused_bits;
    assign unused_bits = ^{instruction[24:15], instruction[11:7], prod[65:64], rem_nx[32]};

    // Next-state, datapath next values and result selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        res_c   = rd_q;
        ld_rd   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = 7'd0;
                    rem_d = 32'd0;
                    if (is_c) begin
                        if (funct3 == 3'b010) begin
                            state_d = S_MULQ;
                            dvs_d   = QV;
                        end else begin
                            state_d = S_MOD;
                        end
                    end else if (!funct3[2]) begin
                        state_d = S_MUL;
                    end else begin
                        state_d = S_DIV;
                        sh_d    = {rs1_mag, 32'd0};
                        dvs_d   = rs2_mag;
                    end
                end
            end
            S_MUL: begin
                res_c   = (op_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
                ld_rd   = 1'b1;
                state_d = S_DONE;
            end
            S_MOD: begin
                res_c   = op_q[0] ? submod_f(a_q, b_q) : addmod_f(a_q, b_q);
                ld_rd   = 1'b1;
                state_d = S_DONE;
            end
            S_DIV: begin
                if (dz_q) begin
                    res_c   = op_q[1] ? a_q : 32'hFFFF_FFFF;
                    ld_rd   = 1'b1;
                    state_d = S_DONE;
                end else if (cnt_q == 7'd32) begin
                    res_c   = op_q[1] ? apply_sign_f(rem_q, negr_q)
                                      : apply_sign_f(sh_q[31:0], negq_q);
                    ld_rd   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    sh_d  = sh_nx;
                    rem_d = rem_nx[31:0];
                    cnt_d = cnt_q + 7'd1;
                end
            end
            S_MULQ: begin
                if (cnt_q == 7'd0) begin
                    sh_d  = prod[63:0];
                    cnt_d = 7'd1;
                end else begin
                    sh_d  = sh_nx;
                    rem_d = rem_nx[31:0];
                    cnt_d = cnt_q + 7'd1;
                    if (cnt_q == 7'd64) begin
                        res_c   = rem_nx[31:0];
                        ld_rd   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and the architecturally visible result register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= 7'd0;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ld_rd) rd_q <= res_c;
        end
    end

    // Operand capture and iterative datapath (no reset needed: gated by FSM)
    always_ff @(posedge clk) begin
        sh_q  <= sh_d;
        rem_q <= rem_d;
        dvs_q <= dvs_d;
        if (accept) begin
            a_q    <= rs1;
            b_q    <= rs2;
            op_q   <= funct3;
            dz_q   <= (rs2 == 32'd0);
            negq_q <= div_sgn_in && (rs1[31] ^ rs2[31]);
            negr_q <= div_sgn_in && rs1[31];
        end
    end

    assign ready = (state_q == S_DONE);
    assign wr    = (state_q == S_DONE);
    assign busy  = (state_q != S_IDLE);
    assign rd    = rd_q;

endmodule

// File: tb/tb_riscv_m_unit.sv
// Directed and randomised bench for riscv_m_unit.
module tb_riscv_m_unit;

    localparam int unsigned QT = 3329;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid;
    logic [31:0] instruction, rs1, rs2;
    logic        wr, busy, ready;
    logic [31:0] rd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_m_unit #(.Q(QT)) dut (
        .clk(clk), .resetn(resetn), .valid(valid), .instruction(instruction),
        .rs1(rs1), .rs2(rs2), .wr(wr), .rd(rd), .busy(busy), .ready(ready)
    );

    function automatic logic [31:0] mi(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    function automatic logic [31:0] ci(input logic [2:0] f3);
        return {7'b0000000, 5'd2, 5'd1, f3, 5'd3, 7'b0001011};
    endfunction

    // Issue one instruction and wait (bounded) for its ready pulse
    task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output bit got);
        int n;
        @(negedge clk);
        instruction = ins; rs1 = a; rs2 = b; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        got = 1'b0; res = 'x; n = 0;
        while (!got && n < 300) begin
            if (ready) begin
                got = 1'b1;
                res = rd;
            end else begin
                @(negedge clk);
                n++;
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; valid = 1'b0; instruction = '0; rs1 = '0; rs2 = '0;
        #12;
        checks++;
        if ({wr, ready, busy, rd} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: wr=%b ready=%b busy=%b rd=%h, required all 0", wr, ready, busy, rd);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_mul();
        logic [31:0] ins [4], a [4], b [4], e [4];
        logic [31:0] r;
        bit got;
        ins[0] = mi(3'b000); a[0] = 32'h1111FFFF; b[0] = 32'h1111FFFF; e[0] = 32'hDDDC0001;
        ins[1] = mi(3'b011); a[1] = 32'h1111FFFF; b[1] = 32'h1111FFFF; e[1] = 32'h01236543;
        ins[2] = mi(3'b001); a[2] = 32'h00000002; b[2] = 32'hFFFFFFFF; e[2] = 32'hFFFFFFFF;
        ins[3] = mi(3'b010); a[3] = 32'hFFFFFFFB; b[3] = 32'h00000004; e[3] = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            run_op(ins[i], a[i], b[i], r, got);
            checks++;
            if (!got || r !== e[i]) begin
                errors++;
                $display("FAIL mul[%0d]: got=%0b rd=%h, required %h", i, got, r, e[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [31:0] ins [9], a [9], b [9], e [9];
        logic [31:0] r;
        bit got;
        ins[0] = mi(3'b100); a[0] = 32'hFFFFFFF3; b[0] = 32'd5;          e[0] = 32'hFFFFFFFE;
        ins[1] = mi(3'b110); a[1] = 32'hFFFFFFF3; b[1] = 32'd5;          e[1] = 32'hFFFFFFFD;
        ins[2] = mi(3'b100); a[2] = -32'sd34;     b[2] = 32'd23;         e[2] = 32'hFFFFFFFF;
        ins[3] = mi(3'b100); a[3] = 32'd34;       b[3] = -32'sd23;       e[3] = 32'hFFFFFFFF;
        ins[4] = mi(3'b100); a[4] = -32'sd34;     b[4] = -32'sd23;       e[4] = 32'd1;
        ins[5] = mi(3'b110); a[5] = 32'd5;        b[5] = 32'hFFFFFFF3;   e[5] = 32'd5;
        ins[6] = mi(3'b101); a[6] = 32'd100;      b[6] = 32'd7;          e[6] = 32'd14;
        ins[7] = mi(3'b111); a[7] = 32'd100;      b[7] = 32'd7;          e[7] = 32'd2;
        ins[8] = mi(3'b101); a[8] = 32'hFFFFFFF3; b[8] = 32'd5;          e[8] = 32'h33333330;
        for (int i = 0; i < 9; i++) begin
            run_op(ins[i], a[i], b[i], r, got);
            checks++;
            if (!got || r !== e[i]) begin
                errors++;
                $display("FAIL div[%0d]: got=%0b rd=%h, required %h", i, got, r, e[i]);
            end
        end
    endtask

    task automatic test_div_corner();
        logic [31:0] ins [6], a [6], b [6], e [6];
        logic [31:0] r;
        bit got;
        ins[0] = mi(3'b100); a[0] = 32'h12345678; b[0] = 32'd0;        e[0] = 32'hFFFFFFFF;
        ins[1] = mi(3'b101); a[1] = 32'h0000000D; b[1] = 32'd0;        e[1] = 32'hFFFFFFFF;
        ins[2] = mi(3'b110); a[2] = 32'hFFFFFFF3; b[2] = 32'd0;        e[2] = 32'hFFFFFFF3;
        ins[3] = mi(3'b111); a[3] = 32'h0000000D; b[3] = 32'd0;        e[3] = 32'h0000000D;
        ins[4] = mi(3'b100); a[4] = 32'h80000000; b[4] = 32'hFFFFFFFF; e[4] = 32'h80000000;
        ins[5] = mi(3'b110); a[5] = 32'h80000000; b[5] = 32'hFFFFFFFF; e[5] = 32'h00000000;
        for (int i = 0; i < 6; i++) begin
            run_op(ins[i], a[i], b[i], r, got);
            checks++;
            if (!got || r !== e[i]) begin
                errors++;
                $display("FAIL div_corner[%0d]: got=%0b rd=%h, required %h", i, got, r, e[i]);
            end
        end
    endtask

    task automatic test_custom();
        logic [31:0] ins [4], a [4], b [4], e [4];
        logic [31:0] r, x, y, ex;
        logic [63:0] p;
        bit got;
        ins[0] = ci(3'b000); a[0] = 32'd3000; b[0] = 32'd1000; e[0] = 32'd671;
        ins[1] = ci(3'b001); a[1] = 32'd5;    b[1] = 32'd10;   e[1] = 32'd3324;
        ins[2] = ci(3'b010); a[2] = 32'd2;    b[2] = 32'd3;    e[2] = 32'd6;
        ins[3] = ci(3'b010); a[3] = QT;       b[3] = 32'd1;    e[3] = 32'd0;
        for (int i = 0; i < 4; i++) begin
            run_op(ins[i], a[i], b[i], r, got);
            checks++;
            if (!got || r !== e[i]) begin
                errors++;
                $display("FAIL custom[%0d]: got=%0b rd=%h, required %h", i, got, r, e[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 100; i++) begin
                if (k == 2) begin
                    x = $urandom; y = $urandom;
                    p = 64'(x) * 64'(y);
                    ex = 32'(p % 64'(QT));
                end else begin
                    x = $urandom_range(0, QT - 1); y = $urandom_range(0, QT - 1);
                    ex = (k == 0) ? (x + y) % QT : (x + QT - y) % QT;
                end
                run_op(ci(3'(k)), x, y, r, got);
                checks++;
                if (!got || r !== ex) begin
                    errors++;
                    $display("FAIL custom_rand op%0d: %h,%h got=%0b rd=%h, required %h", k, x, y, got, r, ex);
                end
            end
        end
    endtask

    task automatic test_handshake();
        int n;
        @(negedge clk);
        instruction = mi(3'b000); rs1 = 32'd7; rs2 = 32'd9; valid = 1'b1;
        checks++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hs_accept_cycle: ready=%b busy=%b, required 0 0", ready, busy);
        end
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("FAIL hs_busy_after_accept: busy=%b ready=%b, required 1 0", busy, ready);
        end
        n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1 || wr !== 1'b1 || busy !== 1'b1 || rd !== 32'd63) begin
            errors++;
            $display("FAIL hs_ready: ready=%b wr=%b busy=%b rd=%h, required 1 1 1 0000003f", ready, wr, busy, rd);
        end
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || wr !== 1'b0 || busy !== 1'b0 || rd !== 32'd63) begin
            errors++;
            $display("FAIL hs_after_ready: ready=%b wr=%b busy=%b rd=%h, required 0 0 0 0000003f", ready, wr, busy, rd);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        bit got;
        int n, extra;
        @(negedge clk);
        instruction = mi(3'b101); rs1 = 32'd100; rs2 = 32'd7; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        instruction = ci(3'b000); rs1 = 32'd1; rs2 = 32'd2; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        got = 1'b0; r = 'x; n = 0;
        while (!got && n < 100) begin
            if (ready) begin got = 1'b1; r = rd; end
            else begin @(negedge clk); n++; end
        end
        checks++;
        if (!got || r !== 32'd14) begin
            errors++;
            $display("FAIL busy_ignore_result: got=%0b rd=%h, required 0000000e", got, r);
        end
        extra = 0;
        repeat (10) begin
            @(negedge clk);
            if (ready || busy) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_ignore_no_second: active cycles=%0d, required 0", extra);
        end
    endtask

    task automatic test_unsupported();
        int act;
        logic [31:0] ins [2];
        ins[0] = ci(3'b011);
        ins[1] = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            instruction = ins[i]; rs1 = 32'd5; rs2 = 32'd6; valid = 1'b1;
            @(negedge clk);
            valid = 1'b0;
            act = 0;
            repeat (10) begin
                if (ready || busy || wr) act++;
                @(negedge clk);
            end
            checks++;
            if (act !== 0 || rd !== 32'd14) begin
                errors++;
                $display("FAIL unsupported[%0d]: active cycles=%0d rd=%h, required 0 and 0000000e", i, act, rd);
            end
        end
    endtask

    task automatic test_reset_mid_div();
        logic [31:0] r;
        bit got;
        int act;
        @(negedge clk);
        instruction = mi(3'b100); rs1 = 32'd1000; rs2 = 32'd3; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({wr, ready, busy, rd} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid_div: wr=%b ready=%b busy=%b rd=%h, required all 0", wr, ready, busy, rd);
        end
        @(negedge clk);
        resetn = 1'b1;
        act = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready || busy) act++;
        end
        checks++;
        if (act !== 0 || rd !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: active cycles=%0d rd=%h, required 0 and 00000000", act, rd);
        end
        run_op(mi(3'b100), -32'sd34, 32'd23, r, got);
        checks++;
        if (!got || r !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL after_reset_div: got=%0b rd=%h, required ffffffff", got, r);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_corner();
        test_custom();
        test_handshake();
        test_back_to_back();
        test_unsupported();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
